// File: rtl/prog_updown_counter_if.sv
// Control and status bundle for prog_updown_counter: pin/register layer (master) to counter (slave).
interface prog_updown_counter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 8
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             oneshot;
  logic [WIDTH-1:0] max_val;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, clear, load, load_val, dir, oneshot, max_val, prescale,
    input  count, running, tc, done
  );

  modport slave (
    input  start, stop, clear, load, load_val, dir, oneshot, max_val, prescale,
    output count, running, tc, done
  );
endinterface

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with prescaler, wrap limit and one-shot mode.
module prog_updown_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  prog_updown_counter_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             wrap;

  assign tick = (state_q == StRun) && (pre_q >= bus.prescale);
  assign wrap = bus.dir ? (count_q >= bus.max_val) : (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    if (bus.clear) begin
      state_d = StIdle;
      count_d = '0;
      pre_d   = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
      pre_d   = '0;
      if (state_q == StDone) state_d = StIdle;
    end else if (bus.stop) begin
      state_d = StIdle;
      pre_d   = '0;
    end else if (bus.start && (state_q != StRun)) begin
      state_d = StRun;
      pre_d   = '0;
    end else if (state_q == StRun) begin
      if (tick) begin
        pre_d = '0;
        if (wrap) begin
          tc_d = 1'b1;
          // One-shot holds the terminal value instead of wrapping.
          if (bus.oneshot) state_d = StDone;
          else             count_d = bus.dir ? '0 : bus.max_val;
        end else begin
          count_d = bus.dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.running = (state_q == StRun);
  assign bus.done    = (state_q == StDone);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed vector table plus hand-written wrap sequences for prog_updown_counter.
module tb_prog_updown_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  prog_updown_counter_if #(.WIDTH(8), .PRE_W(8)) bus ();

  prog_updown_counter #(.WIDTH(8), .PRE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst_n, start, stop, clear, load;
    logic [7:0] load_val;
    logic       dir, oneshot;
    logic [7:0] max_val, prescale;
    logic [7:0] exp_count;
    logic       exp_run, exp_tc, exp_done;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   errors = 0;

  task automatic add(input logic r, s, p, c, l, input logic [7:0] lv, input logic d, os,
                     input logic [7:0] mx, ps, ec, input logic er, et, ed);
    vec_t v;
    v = '{r, s, p, c, l, lv, d, os, mx, ps, ec, er, et, ed};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, want %0d", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, s, p, c, l, input logic [7:0] lv, input logic d, os,
                       input logic [7:0] mx, ps);
    rst_n        = r;
    bus.start    = s;
    bus.stop     = p;
    bus.clear    = c;
    bus.load     = l;
    bus.load_val = lv;
    bus.dir      = d;
    bus.oneshot  = os;
    bus.max_val  = mx;
    bus.prescale = ps;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] mdl;
    logic       mtc;
    int         tc_cnt;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd9, 8'd2);

    //  rst st sp cl ld lv     dir os mx     ps     count  run tc done
    add(0, 1, 0, 0, 1, 8'd55, 1, 0, 8'd9, 8'd2, 8'd0,  0, 0, 0); // reset dominates
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd0,  0, 0, 0);
    add(1, 1, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd0,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd0,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd0,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd1,  1, 0, 0);
    add(1, 1, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd1,  1, 0, 0); // start in RUN ignored
    add(1, 1, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd1,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd2,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd2, 8'd2,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd0, 8'd3,  1, 0, 0); // prescale lowered
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd0, 8'd4,  1, 0, 0);
    add(1, 0, 0, 0, 1, 8'd20, 1, 0, 8'd9, 8'd0, 8'd20, 1, 0, 0); // load above max
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd0, 8'd0,  1, 1, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd0, 8'd1,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  0, 0, 8'd9, 8'd0, 8'd0,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  0, 0, 8'd9, 8'd0, 8'd9,  1, 1, 0); // down wrap to max
    add(1, 0, 0, 0, 0, 8'd0,  0, 0, 8'd9, 8'd0, 8'd8,  1, 0, 0);
    add(1, 1, 1, 0, 0, 8'd0,  0, 0, 8'd9, 8'd0, 8'd8,  0, 0, 0); // stop beats start
    add(1, 0, 0, 0, 0, 8'd0,  0, 0, 8'd9, 8'd0, 8'd8,  0, 0, 0);
    add(1, 0, 0, 1, 0, 8'd0,  0, 0, 8'd9, 8'd0, 8'd0,  0, 0, 0);
    add(1, 0, 0, 0, 1, 8'd3,  0, 1, 8'd9, 8'd0, 8'd3,  0, 0, 0); // oneshot down
    add(1, 1, 0, 0, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd3,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd2,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd1,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd0,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd0,  0, 1, 1);
    add(1, 0, 0, 0, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd0,  0, 0, 1);
    add(1, 1, 0, 0, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd0,  1, 0, 0); // restart from DONE
    add(1, 0, 0, 0, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd0,  0, 1, 1);
    add(1, 0, 0, 1, 0, 8'd0,  0, 1, 8'd9, 8'd0, 8'd0,  0, 0, 0);
    add(1, 1, 0, 0, 0, 8'd0,  1, 0, 8'd0, 8'd0, 8'd0,  1, 0, 0); // max_val = 0
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd0, 8'd0, 8'd0,  1, 1, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd0, 8'd0, 8'd0,  1, 1, 0);
    add(1, 0, 0, 0, 0, 8'd0,  0, 0, 8'd0, 8'd0, 8'd0,  1, 1, 0);
    add(1, 0, 0, 0, 1, 8'd5,  1, 0, 8'd9, 8'd0, 8'd5,  1, 0, 0);
    add(0, 1, 0, 0, 1, 8'd7,  1, 0, 8'd9, 8'd0, 8'd0,  0, 0, 0); // reset mid-run
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd0, 8'd0,  0, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 0, 8'd9, 8'd0, 8'd0,  0, 0, 0);
    add(1, 0, 0, 0, 1, 8'd8,  1, 1, 8'd9, 8'd0, 8'd8,  0, 0, 0); // oneshot up
    add(1, 1, 0, 0, 0, 8'd0,  1, 1, 8'd9, 8'd0, 8'd8,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 1, 8'd9, 8'd0, 8'd9,  1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd0,  1, 1, 8'd9, 8'd0, 8'd9,  0, 1, 1);
    add(1, 0, 0, 0, 1, 8'd2,  1, 1, 8'd9, 8'd0, 8'd2,  0, 0, 0); // load leaves DONE

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].start, vecs[i].stop, vecs[i].clear, vecs[i].load,
            vecs[i].load_val, vecs[i].dir, vecs[i].oneshot, vecs[i].max_val, vecs[i].prescale);
      cycle();
      check("vec_count", i, 32'(bus.count), 32'(vecs[i].exp_count));
      check("vec_running", i, 32'(bus.running), 32'(vecs[i].exp_run));
      check("vec_tc", i, 32'(bus.tc), 32'(vecs[i].exp_tc));
      check("vec_done", i, 32'(bus.done), 32'(vecs[i].exp_done));
    end

    // Full 8-bit wrap at prescale 0.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd255, 8'd0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd255, 8'd0);
    cycle();
    check("full_start_run", 0, 32'(bus.running), 32'd1);
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      check("full_count", i, 32'(bus.count), 32'((i + 1) % 256));
      check("full_tc", i, 32'(bus.tc), (i == 255) ? 32'd1 : 32'd0);
    end
    check("full_running", 0, 32'(bus.running), 32'd1);
    cycle();
    check("full_tc_after", 0, 32'(bus.tc), 32'd0);

    // Continuous 0..9 with prescale 2: a step every 3 cycles, 30 cycles per wrap.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd9, 8'd2);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd9, 8'd2);
    cycle();
    bus.start = 1'b0;
    mdl = 8'd0;
    tc_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      cycle();
      mtc = 1'b0;
      if (k % 3 == 0) begin
        if (mdl == 8'd9) begin
          mdl = 8'd0;
          mtc = 1'b1;
        end else begin
          mdl = mdl + 8'd1;
        end
      end
      if (bus.tc) tc_cnt++;
      check("pre_count", k, 32'(bus.count), 32'(mdl));
      check("pre_tc", k, 32'(bus.tc), 32'(mtc));
    end
    check("pre_tc_total", 0, 32'(tc_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
